uart_rx_mv: RTL and testbench

//   8N1 UART receiver: the receive end of the board's UART link, paired with the

---
 rtl/uart_rx_mv.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_mv.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mv.sv
// 8N1 UART receiver with 2-FF input sync, 3-sample majority vote and ready/ready_clr handshake.
// Optional parity stage (8E1/8O1) enabled by defining UART_RX_PARITY_EN.
module uart_rx_mv #(
    parameter int CLOCKS_PER_PULSE = 5208,
    parameter int PARITY_ODD       = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    input  logic       ready_clr,
    output logic       ready,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] CNT_V1   = CW'(CLOCKS_PER_PULSE - 2);
    localparam logic [CW-1:0] CNT_V0   = CW'(CLOCKS_PER_PULSE - 3);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          sync1_q, sync2_q;
    logic          v0_q, v0_d, v1_q, v1_d;
    logic          ready_q, ready_d;
    logic [7:0]    data_q, data_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic rx_s;
    logic vote;
    logic bit_end;
    logic deliver;
    logic stop_bad;
    logic clr;

`ifdef UART_RX_PARITY_EN
    logic par_q, par_d;
    logic parity_err_q, parity_err_d;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign rx_s    = sync2_q;
    assign vote    = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
    assign bit_end = (cnt_q == CNT_LAST);
    assign clr     = ready_clr & ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        v0_d      = (cnt_q == CNT_V0) ? rx_s : v0_q;
        v1_d      = (cnt_q == CNT_V1) ? rx_s : v1_q;
        deliver   = 1'b0;
        stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Leaving START at half a bit puts every later cnt=CPP-1 at mid-bit.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    shift_d = {vote, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    par_d   = vote;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    if (vote) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_d     = ready_q;
        data_d      = data_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (deliver) begin
            ready_d     = 1'b1;
            data_d      = shift_q;
            frame_err_d = 1'b0;
        end else if (clr) begin
            ready_d = 1'b0;
        end
        if (stop_bad) begin
            frame_err_d = 1'b1;
        end
        // A consumer acknowledge in the delivery cycle wins over the overrun.
        if (clr) begin
            overrun_d = 1'b0;
        end else if (deliver && ready_q) begin
            overrun_d = 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
        if (deliver) begin
            parity_err_d = ((^shift_q) ^ par_q) != (PARITY_ODD != 0);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            ready_q     <= 1'b0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            ready_q     <= ready_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign ready     = ready_q;
    assign data_out  = data_q;
    assign busy      = (state_q != S_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_mv.sv
// Directed bench for uart_rx_mv at 16 clocks per bit; parity frames when UART_RX_PARITY_EN is defined.
module tb_uart_rx_mv;

    localparam int CPP     = 16;
    localparam int PAR_ODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM = 171;
`else
    localparam int LAT_NOM = 155;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       rx;
    logic       ready_clr;
    logic       ready;
    logic [7:0] data_out;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    uart_rx_mv #(
        .CLOCKS_PER_PULSE(CPP),
        .PARITY_ODD      (PAR_ODD)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx        (rx),
        .ready_clr (ready_clr),
        .ready     (ready),
        .data_out  (data_out),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic [7:0] b;
        logic       stop;
        logic       exp_ready;
        logic [7:0] exp_data;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic good_par(input logic [7:0] b);
        return (^b) ^ (PAR_ODD != 0);
    endfunction

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPP) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic pbit, input int gap_bits);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
`else
        if (pbit === 1'bx) rx = 1'b1;
`endif
        drive_bit(stop);
        for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
    endtask

    task automatic pulse_clr();
        ready_clr = 1'b1;
        @(negedge clk);
        ready_clr = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic e_rdy, input logic [7:0] e_dat,
                             input logic e_busy, input logic e_fe, input logic e_ov, input logic e_pe);
        check({tag, ".ready"},      {7'b0, ready},      {7'b0, e_rdy});
        check({tag, ".data_out"},   data_out,           e_dat);
        check({tag, ".busy"},       {7'b0, busy},       {7'b0, e_busy});
        check({tag, ".frame_err"},  {7'b0, frame_err},  {7'b0, e_fe});
        check({tag, ".overrun"},    {7'b0, overrun},    {7'b0, e_ov});
        check({tag, ".parity_err"}, {7'b0, parity_err}, {7'b0, e_pe});
    endtask

    initial begin
        int  lat;
        bit  found;
        logic [7:0] b;

        vecs[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h22, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1};

        rstn = 1'b0;
        rx = 1'b1;
        ready_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Latency from the rx falling edge to ready
        lat = 0;
        found = 1'b0;
        fork
            send_frame(8'hA5, 1'b1, good_par(8'hA5), 2);
            begin
                for (int k = 1; k <= 250; k++) begin
                    @(negedge clk);
                    if (!found && ready) begin
                        lat = k;
                        found = 1'b1;
                    end
                end
            end
        join
        checks++;
        if (!(lat >= LAT_NOM - 2 && lat <= LAT_NOM + 2)) begin
            errors++;
            $display("FAIL latency: got %0d clk expected %0d +/-2 clk", lat, LAT_NOM);
        end
        check_all("first", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Short low glitch on an idle line
        pulse_clr();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        check("glitch.busy_mid", {7'b0, busy}, 8'h01);
        repeat (2 * CPP) @(negedge clk);
        check_all("glitch", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bad stop bit followed by a break, then a good frame
        send_frame(8'h3C, 1'b0, good_par(8'h3C), 0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        check_all("break", 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("break.busy_after", {7'b0, busy}, 8'h00);
        send_frame(8'h81, 1'b1, good_par(8'h81), 2);
        check_all("after_break", 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].clr) pulse_clr();
            send_frame(vecs[i].b, vecs[i].stop, good_par(vecs[i].b), 2);
            check_all($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_data, 1'b0,
                      vecs[i].exp_fe, vecs[i].exp_ov, 1'b0);
        end

        pulse_clr();
        check_all("clr", 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_clr();
        check_all("clr_idle", 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of data bit 4
        send_frame(8'h33, 1'b1, good_par(8'h33), 1);
        send_frame(8'h44, 1'b1, good_par(8'h44), 1);
        check_all("pre_reset", 1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0);
        b = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        repeat (CPP / 2) @(negedge clk);
        check("pre_reset.busy", {7'b0, busy}, 8'h01);
        rstn = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        check_all("mid_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (12 * CPP) @(negedge clk);
        check_all("post_reset_idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, good_par(8'h5A), 2);
        check_all("post_reset", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
        pulse_clr();
        send_frame(8'h07, 1'b1, good_par(8'h07), 2);
        check_all("par_good", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        pulse_clr();
        send_frame(8'h07, 1'b1, ~good_par(8'h07), 2);
        check_all("par_bad", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
        pulse_clr();
        check("par_bad.sticky_on_clr", {7'b0, parity_err}, 8'h01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
